// File: rtl/univ_shift_reg.sv
// univ_shift_reg: N-bit universal register with an autonomous LSB-first serialiser.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - synchronous active-high reset
//   en     - global enable; low freezes po, counter and FSM (done still clears)
//   mode   - operation select, honoured only while idle:
//            000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 ashr, 111 clear
//   pi     - parallel data in
//   sin_l  - serial bit entering at the MSB on right shifts (and while serialising)
//   sin_r  - serial bit entering at the LSB on left shifts
//   start  - begin serialising pi; only sampled while idle, wins over mode
//   po     - registered contents
//   sout   - po[0]
//   busy   - registered, high while serialising
//   done   - registered one-cycle pulse after the last serial bit
module univ_shift_reg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [N-1:0] pi,
    input  logic         sin_l,
    input  logic         sin_r,
    input  logic         start,
    output logic [N-1:0] po,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e         state_q;
    logic [N-1:0]   po_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   mode_po;

    // Result of the idle-state mode operation on the current contents.
    always_comb begin
        mode_po = po_q;
        unique case (mode)
            3'b000: mode_po = po_q;
            3'b001: mode_po = pi;
            3'b010: mode_po = {po_q[N-2:0], sin_r};
            3'b011: mode_po = {sin_l, po_q[N-1:1]};
            3'b100: mode_po = {po_q[N-2:0], po_q[N-1]};
            3'b101: mode_po = {po_q[0], po_q[N-1:1]};
            3'b110: mode_po = {po_q[N-1], po_q[N-1:1]};
            3'b111: mode_po = '0;
            default: mode_po = po_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            po_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!en) begin
            // Stall: everything holds except the done pulse, which never outlives one cycle.
            done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        po_q    <= pi;
                        cnt_q   <= '0;
                        state_q <= StShift;
                        busy_q  <= 1'b1;
                    end else begin
                        po_q <= mode_po;
                    end
                end
                StShift: begin
                    po_q <= {sin_l, po_q[N-1:1]};
                    if (cnt_q == CntLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign po   = po_q;
    assign sout = po_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule
